// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one GROUP-bit look-ahead group per stage,
// global-stall valid/ready handshake, one result per clock at any WIDTH.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (GROUP < 1) begin : g_bad_group
            $error("pipelined_cla_adder: GROUP must be at least 1");
        end else if (WIDTH % GROUP != 0) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    localparam int GRP    = (GROUP < 1) ? 1 : GROUP;
    localparam int STAGES = (WIDTH / GRP < 1) ? 1 : WIDTH / GRP;
    localparam int LAST   = STAGES - 1;

    // Every carry is a flat sum of generate/propagate products, not a ripple chain.
    function automatic logic [GRP:0] cla_group(input logic [GRP-1:0] x,
                                               input logic [GRP-1:0] y,
                                               input logic           c_in);
        logic [GRP-1:0] g;
        logic [GRP-1:0] p;
        logic [GRP:0]   c;
        logic           term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < GRP; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & c_in);
        end
        return {c[GRP], p ^ c[GRP-1:0]};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_s     [STAGES];
    logic             st_c     [STAGES];
    logic             st_v     [STAGES];
    logic [GRP:0]     grp_res  [STAGES];
    logic [WIDTH-1:0] s_next   [STAGES];
    logic             ovf_next;

    // Operands shift down by GRP per stage so the active group is always at [GRP-1:0];
    // finished sum groups enter at the top and arrive aligned after the last stage.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

    // NOTE: every array element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        st_a[0] = a;
        st_b[0] = b ^ {WIDTH{sub}};
        st_c[0] = cin ^ sub;
        st_s[0] = '0;
        st_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_s[k] = s_q[k-1];
            st_v[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            grp_res[k] = cla_group(st_a[k][GRP-1:0], st_b[k][GRP-1:0], st_c[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_next[k] = (st_s[k] >> GRP) | (WIDTH'(grp_res[k][GRP-1:0]) << (WIDTH - GRP));
        end
        ovf_next = (st_a[LAST][GRP-1] == st_b[LAST][GRP-1]) &&
                   (grp_res[LAST][GRP-1] != st_a[LAST][GRP-1]);
    end

    // NOTE: state uses non-blocking assignments so all stages sample the pre-edge values.
    // Data only loads behind a valid bit, so bubbles leave sum/cout/ovf untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= st_v[k];
                if (st_v[k]) begin
                    c_q[k] <= grp_res[k][GRP];
                    s_q[k] <= s_next[k];
                end
            end
            if (st_v[LAST]) begin
                ovf_q <= ovf_next;
            end
        end
    end

    // NOTE: the operand pipes carry no reset; their contents are only consumed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (st_v[k]) begin
                    a_q[k] <= st_a[k] >> GRP;
                    b_q[k] <= st_b[k] >> GRP;
                end
            end
        end
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor. Successor to the 8-bit combinational CLA.
- The operand width is split into GROUP-bit look-ahead groups, with one group resolved per pipeline stage. This gives one result per clock at any width.
- A valid/ready handshake on both the input and output sides lets the block sit in a streaming datapath, e.g. between the operand register file and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per CLA group and per pipeline stage; STAGES = WIDTH/GROUP (derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: clk and rst are one clock domain. rst is synchronous and active-high.
  - While rst=1 at a rising edge: all stage valid bits clear, out_valid=0, sum=0, cout=0, ovf=0.
  - In-flight operations are discarded and never appear at the output.
  - in_ready=1 the cycle after reset deasserts.
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. Here cout=1 means no borrow.
  - ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is the effective (inverted-if-sub) operand.
  - All widths are exact; there is no truncation beyond WIDTH+1.
- Pipeline:
  - Stage k (0..STAGES-1) computes group k using generate/propagate look-ahead within the group. Its carry-in is the registered carry from stage k-1; stage 0 uses the effective cin.
  - Not-yet-processed upper operand bits and already-produced lower sum bits travel alongside in stage registers.
  - The last stage registers sum/cout/ovf directly; the outputs are registered, with no combinational path from a/b to sum.
- Latency and throughput:
  - Latency = STAGES cycles: an operation accepted at edge N is visible with out_valid=1 after edge N+STAGES-1 (16/4: the 4th edge including the accept).
  - Throughput is 1 op/cycle.
- Handshake:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready at a rising edge.
  - advance = !out_valid || out_ready, and in_ready = advance. This is a global stall; there is no bubble collapse.
  - When advance=0, every stage register holds. sum/cout/ovf/out_valid must stay stable until the transfer completes.
  - in_valid=0 with advance=1 inserts a bubble (valid bit 0). Bubbles never raise out_valid.
  - Ordering is strictly FIFO; no op is lost or duplicated.
- Boundaries:
  - Simultaneous output transfer and input accept in the same cycle is legal with no stall.
  - out_ready may toggle arbitrarily; the held output must not change.
  - a/b/cin/sub are sampled only on accept; values when in_valid=0 or in_ready=0 are don't-care.
  - rst wins over all handshake activity in the same cycle.
- Elaboration: fail if WIDTH % GROUP != 0 or GROUP < 1.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0 throughout and for 4 cycles after release unless ops are accepted.
- Carry ripple across all groups: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 4 edges after accept.
- Signed overflow:
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> 0x0000, cout=1, ovf=1.
- Subtract:
  - 0x0005-0x0007, cin=0 -> 0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
  - 0x0010-0x0003, cin=1 -> 0x000C, cout=1.
- Stream plus backpressure: 30 back-to-back ops with a+=5, b+=7, cin toggling, sub toggling every 3.
  - out_ready low on cycles 10-13, with random bubbles on in_valid.
  - Every result must match the reference model, in order, with no loss or duplication.
  - Outputs must be stable while stalled, and in_ready=0 exactly while out_valid && !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, none of the 3 results ever appear; a new op after release returns correctly after 4 cycles.
